// File: rtl/top_k_feeder.sv
// top_k_feeder: unpacks 512-bit request frames into the 32-bit element stream of the top-k chain.
// Define TOP_K_FEEDER_STATS_EN to add the frames_done / elems_done counters.
module top_k_feeder #(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned INTEGER_SIZE = 32,
    parameter int unsigned COUNT_BITS   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_data_TVALID,
    output logic                    rx_data_TREADY,
    input  logic [DATA_WIDTH-1:0]   rx_data_TDATA,
    input  logic                    rx_data_TLAST,
    output logic                    tx_data_TVALID,
    input  logic                    tx_data_TREADY,
    output logic [INTEGER_SIZE-1:0] tx_data_TDATA,
    output logic                    tx_data_TLAST,
    output logic                    tx_clear,
    output logic                    err_short,
    output logic                    err_empty
`ifdef TOP_K_FEEDER_STATS_EN
    ,
    output logic [31:0]             frames_done,
    output logic [31:0]             elems_done
`endif
);
    localparam int unsigned LANES     = DATA_WIDTH / INTEGER_SIZE;
    localparam int unsigned LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, UNPACK, DRAIN} state_t;
    state_t state, state_next;

    logic [15:0]             mask;
    logic [COUNT_BITS-1:0]   n_count, emitted, remaining, hdr_count;
    logic [LANE_BITS-1:0]    lane;
    logic [INTEGER_SIZE-1:0] buffer [LANES];
    logic [INTEGER_SIZE-1:0] hdr_word;
    logic                    beat_last, ready_en;
    logic                    rx_hs, tx_hs, last_lane, rem_one, unpack_last;

    assign hdr_count   = rx_data_TDATA[COUNT_BITS+31:32];
    assign remaining   = n_count - emitted;
    assign rem_one     = (remaining == COUNT_BITS'(1));
    assign last_lane   = (lane == LAST_LANE);
    assign unpack_last = rem_one || (beat_last && last_lane);
    assign rx_hs       = rx_data_TVALID && rx_data_TREADY;
    assign tx_hs       = tx_data_TVALID && tx_data_TREADY;

    always_comb begin
        hdr_word       = '0;
        hdr_word[15:0] = mask;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rx_hs) begin
                if (hdr_count == '0)     state_next = rx_data_TLAST ? IDLE : DRAIN;
                else if (!rx_data_TLAST) state_next = HDR;
            end
            HDR:  if (tx_hs) state_next = LOAD;
            LOAD: if (rx_hs) state_next = UNPACK;
            UNPACK: if (tx_hs) begin
                if (unpack_last)    state_next = (rem_one && !beat_last) ? DRAIN : IDLE;
                else if (last_lane) state_next = rx_hs ? UNPACK : LOAD;
            end
            DRAIN: if (rx_hs && rx_data_TLAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ready_en keeps rx_data_TREADY low for the first cycle out of reset
    always_comb begin
        rx_data_TREADY = 1'b0;
        tx_data_TVALID = 1'b0;
        tx_data_TDATA  = '0;
        tx_data_TLAST  = 1'b0;
        tx_clear       = 1'b0;
        case (state)
            IDLE: rx_data_TREADY = ready_en;
            HDR: begin
                tx_data_TVALID = 1'b1;
                tx_clear       = 1'b1;
                tx_data_TDATA  = hdr_word;
            end
            LOAD: rx_data_TREADY = 1'b1;
            UNPACK: begin
                tx_data_TVALID = 1'b1;
                tx_data_TDATA  = buffer[lane];
                tx_data_TLAST  = unpack_last;
                rx_data_TREADY = last_lane && !unpack_last && tx_data_TREADY;
            end
            DRAIN: rx_data_TREADY = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask      <= '0;
            n_count   <= '0;
            emitted   <= '0;
            lane      <= '0;
            beat_last <= 1'b0;
            err_short <= 1'b0;
            err_empty <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (state == IDLE && rx_hs) begin
                if (hdr_count != '0 && !rx_data_TLAST) begin
                    mask    <= rx_data_TDATA[15:0];
                    n_count <= hdr_count;
                    emitted <= '0;
                end else begin
                    err_empty <= 1'b1;
                end
            end
            if (state == UNPACK && tx_hs) begin
                emitted <= emitted + COUNT_BITS'(1);
                lane    <= lane + LANE_BITS'(1);
                if (unpack_last && beat_last && !rem_one) err_short <= 1'b1;
            end
            // a beat loaded on the final-lane handshake overrides the lane increment
            if ((state == LOAD || state == UNPACK) && rx_hs) begin
                lane      <= '0;
                beat_last <= rx_data_TLAST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == LOAD || state == UNPACK) && rx_hs) begin
            for (int unsigned i = 0; i < LANES; i++)
                buffer[i] <= rx_data_TDATA[i*INTEGER_SIZE +: INTEGER_SIZE];
        end
    end

`ifdef TOP_K_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_done <= '0;
            elems_done  <= '0;
        end else begin
            if (tx_hs && tx_data_TLAST) frames_done <= frames_done + 32'd1;
            if (tx_hs && !tx_clear)     elems_done  <= elems_done + 32'd1;
        end
    end
`endif

endmodule
